mem_slave_wait: RTL and testbench
=================================

// Module: mem_slave_wait
// PURPOSE
//  Synthesisable word-addressed RAM slave on the core's native memory bus
//  (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata/mem_instr).
//  Generalises the bench memory model: parametrised base/depth, programmable
//  wait states, error response for unmapped addresses, abort on valid drop,
//  and per-type access counters for bench and FPGA debug.
// PARAMETERS
//  ADDR_BASE    32'h0000_0000  byte address of word 0; must be 4-byte aligned
//  DEPTH_WORDS  256            number of 32-bit words (power of two, >=2)
//  WAIT_CYCLES  0              extra cycles between accept and mem_ready (0..15)
//  CNT_W        32             width of each statistics counter
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      asynchronous reset, active-high
//  mem_valid    in   1      request valid; held by master until mem_ready
//  mem_instr    in   1      request is an instruction fetch (stats only)
//  mem_addr     in   32     byte address; bits [1:0] ignored
//  mem_wdata    in   32     write data
//  mem_wstrb    in   4      byte write enables; 4'b0000 = read
//  mem_ready    out  1      one-cycle completion pulse
//  mem_rdata    out  32     read data, valid while mem_ready=1
//  mem_error    out  1      with mem_ready: address unmapped, no access done
//  stat_clear   in   1      synchronous clear of all counters
//  stat_ifetch  out  CNT_W  completed fetches (mem_instr=1, error=0)
//  stat_read    out  CNT_W  completed data reads (wstrb=0, instr=0, error=0)
//  stat_write   out  CNT_W  completed writes (wstrb!=0, error=0)
// BEHAVIOUR
//  - Reset: state IDLE; mem_ready=0, mem_error=0, mem_rdata=0, counters=0.
//    RAM contents NOT reset (preserved across reset). Reset mid-transaction:
//    transaction dropped, no write, no mem_ready.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: mem_valid=1 at edge N -> latch addr/wdata/wstrb/instr, load wait
//      counter with WAIT_CYCLES; go WAIT (or straight to RESP if WAIT_CYCLES=0).
//    WAIT: decrement each cycle; at 0 -> RESP. mem_valid=0 in WAIT -> abort,
//      back to IDLE, no write, no ready, no count.
//    RESP: mem_ready=1 for exactly one cycle; go IDLE.
//  - Latency: mem_ready visible in cycle after edge N+WAIT_CYCLES
//    (WAIT_CYCLES=0: ready one cycle after valid, identical to bench model).
//  - After RESP at least one IDLE cycle: a still-high mem_valid is re-sampled
//    as a new request one cycle after the ready pulse (no double completion).
//  - Hit: ADDR_BASE <= addr < ADDR_BASE+4*DEPTH_WORDS (unsigned, no wrap).
//    Index = (addr-ADDR_BASE)>>2. Read returns pre-write word (read-before-
//    write) on every hit incl. writes; only strobed lanes updated.
//  - Miss: mem_ready=1, mem_error=1, mem_rdata=32'h0, RAM untouched,
//    counters unchanged. mem_error=0 whenever mem_ready=0.
//  - mem_rdata holds last value between responses.
//  - Counters increment in RESP, wrap modulo 2**CNT_W; stat_clear wins over
//    a same-cycle increment.
// STRUCTURE
//  - Package mem_slave_pkg: state enum {IDLE,WAIT,RESP}, WSTRB_NONE const,
//    function addr_hit(addr,base,depth).
//  - Sub-module byte_ram: DEPTH_WORDS x 32, 4 byte-lane write enables,
//    synchronous read-before-write port; FSM, decode and counters stay here.
// TESTING
//  - WAIT_CYCLES=0, sw 0x0000_00AA to 0x3FC then lw 0x3FC -> ready 1 cycle
//    after each valid, rdata=0x0000_00AA, stat_write=1, stat_read=1.
//  - WAIT_CYCLES=3, fetch 0x000 holding 0x3FC00093 -> ready exactly 4 cycles
//    after valid sampled, rdata=0x3FC00093, stat_ifetch=1.
//  - Word 0x12345678, wstrb=4'b0101 wdata=0xAABBCCDD -> response 0x12345678,
//    next read 0x12BB56DD.
//  - Read 0x400 with DEPTH_WORDS=256, base 0 -> ready+error, rdata=0, counters
//    unchanged; write 0x400 leaves all RAM unchanged.
//  - WAIT_CYCLES=5, drop valid after 2 cycles of a write -> no ready, RAM
//    unchanged; assert reset in WAIT -> ready stays 0, counters 0, RAM kept.
//  - Run counter-loop program (li/sw/lw/addi/sw/j) 200 cycles -> word 0x3FC
//    increments each loop; stat_clear with write in RESP -> counters read 0.

Source files
------------

// File: rtl/mem_slave_wait_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_slave_pkg
// Purpose  : Shared types, constants and address decode helper for the
//            wait-state RAM slave on the native memory bus.
// Revision : 1.0  initial release
// ============================================================================
package mem_slave_pkg;

    // Transaction sequencing states of the slave
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A strobe pattern of all zeros marks a read request
    localparam logic [3:0] WSTRB_NONE = 4'b0000;

    // True when the word containing addr lies inside [base, base + 4*depth).
    // The span is computed in 34 bits so a window ending exactly at the top
    // of the address space does not wrap.
    function automatic logic addr_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
        logic [31:0] word_addr;
        logic [33:0] offset;
        logic [33:0] span;
        word_addr = addr & 32'hFFFF_FFFC;
        offset    = {2'b00, word_addr} - {2'b00, base};
        span      = {depth, 2'b00};
        return (word_addr >= base) && (offset < span);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_slave_wait_if.sv
`default_nettype none
// ============================================================================
// Interface : mem_slave_wait_if
// Purpose   : Native memory bus (valid/ready handshake) between a core-side
//             master and a memory slave.
// Revision  : 1.0  initial release
// ============================================================================
interface mem_slave_wait_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_error;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata, mem_error
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata, mem_error
    );
endinterface
`default_nettype wire

// File: rtl/mem_slave_wait_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : byte_ram
// Purpose  : DEPTH_WORDS x 32 single-port RAM built from four byte lanes,
//            each with its own write enable. Synchronous read returns the
//            word as it was before a same-cycle write. Contents are never
//            reset.
// Revision : 1.0  initial release
// ============================================================================
module byte_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  wire logic          clk,
    input  wire logic          en,
    input  wire logic [3:0]    we,
    input  wire logic [AW-1:0] addr,
    input  wire logic [31:0]   wdata,
    output logic      [31:0]   rdata
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_q;

        // Byte lane: read old contents, then optionally overwrite
        always_ff @(posedge clk) begin
            if (en) begin
                r_q <= r_mem[addr];
                if (we[i]) begin
                    r_mem[addr] <= wdata[8*i +: 8];
                end
            end
        end

        assign rdata[8*i +: 8] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/mem_slave_wait.sv
`default_nettype none
// ============================================================================
// Module   : mem_slave_wait
// Purpose  : Word-addressed RAM slave with programmable wait states, error
//            response for unmapped addresses, abort when valid drops during
//            the wait, and per-type access statistics.
// Revision : 1.0  initial release
// ============================================================================
module mem_slave_wait
    import mem_slave_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 0,
    parameter int          CNT_W       = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    mem_slave_wait_if.slave       bus,
    input  wire logic             stat_clear,
    output logic      [CNT_W-1:0] stat_ifetch,
    output logic      [CNT_W-1:0] stat_read,
    output logic      [CNT_W-1:0] stat_write
);

    localparam int         c_AW        = $clog2(DEPTH_WORDS);
    // The counter counts down to zero, so it starts one below the wait count
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_instr;
    logic        r_ready;
    logic        r_error;
    logic        r_sel_ram;
    logic [31:0] r_rdata_hold;

    logic [31:0]     w_acc_addr;
    logic [31:0]     w_acc_wdata;
    logic [3:0]      w_acc_wstrb;
    logic [31:0]     w_offset;
    logic [c_AW-1:0] w_index;
    logic            w_hit;
    logic            w_go_resp;
    logic            w_ram_en;
    logic [3:0]      w_ram_we;
    logic [31:0]     w_ram_rdata;

    // With zero wait states the RAM is accessed on the accepting edge, so the
    // live bus is used; otherwise the request latched at accept is used.
    assign w_acc_addr  = (r_state == IDLE) ? bus.mem_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? bus.mem_wdata : r_wdata;
    assign w_acc_wstrb = (r_state == IDLE) ? bus.mem_wstrb : r_wstrb;

    assign w_offset = w_acc_addr - ADDR_BASE;
    assign w_index  = c_AW'(w_offset >> 2);
    assign w_hit    = addr_hit(w_acc_addr, ADDR_BASE, 32'(DEPTH_WORDS));

    // Edge on which the transaction commits: RAM access and response launch
    assign w_go_resp = ((r_state == IDLE) && bus.mem_valid && (WAIT_CYCLES == 0)) ||
                       ((r_state == WAIT) && bus.mem_valid && (r_wait_cnt == 4'd0));

    assign w_ram_en = w_go_resp && w_hit;
    assign w_ram_we = w_ram_en ? w_acc_wstrb : WSTRB_NONE;

    byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (c_AW)
    ) u_ram (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_ram_we),
        .addr  (w_index),
        .wdata (w_acc_wdata),
        .rdata (w_ram_rdata)
    );

    // Request sequencing with registered ready/error and held read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wait_cnt   <= 4'd0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_wstrb      <= WSTRB_NONE;
            r_instr      <= 1'b0;
            r_ready      <= 1'b0;
            r_error      <= 1'b0;
            r_sel_ram    <= 1'b0;
            r_rdata_hold <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.mem_valid) begin
                        r_addr     <= bus.mem_addr;
                        r_wdata    <= bus.mem_wdata;
                        r_wstrb    <= bus.mem_wstrb;
                        r_instr    <= bus.mem_instr;
                        r_wait_cnt <= c_WAIT_LOAD;
                        r_state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.mem_valid) begin
                        r_state <= IDLE;
                    end else if (r_wait_cnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    r_ready   <= 1'b0;
                    r_error   <= 1'b0;
                    r_sel_ram <= 1'b0;
                    if (r_sel_ram) begin
                        r_rdata_hold <= w_ram_rdata;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Launch the one-cycle response; a miss forces read data to zero
            if (w_go_resp) begin
                r_ready   <= 1'b1;
                r_error   <= ~w_hit;
                r_sel_ram <= w_hit;
                if (!w_hit) begin
                    r_rdata_hold <= 32'h0;
                end
            end
        end
    end

    assign bus.mem_ready = r_ready;
    assign bus.mem_error = r_error;
    assign bus.mem_rdata = r_sel_ram ? w_ram_rdata : r_rdata_hold;

    // Statistics: count successful completions; clear takes priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_ifetch <= '0;
            stat_read   <= '0;
            stat_write  <= '0;
        end else if (stat_clear) begin
            stat_ifetch <= '0;
            stat_read   <= '0;
            stat_write  <= '0;
        end else if ((r_state == RESP) && !r_error) begin
            if (r_instr) begin
                stat_ifetch <= stat_ifetch + 1'b1;
            end
            if ((r_wstrb == WSTRB_NONE) && !r_instr) begin
                stat_read <= stat_read + 1'b1;
            end
            if (r_wstrb != WSTRB_NONE) begin
                stat_write <= stat_write + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_slave_wait.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_slave_wait
// Purpose  : Self-checking bench for mem_slave_wait. Two instances (zero and
//            three wait states) share one stimulus driver; a queue carries
//            expected responses to a monitor that compares each ready pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_slave_wait;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        known;
    } exp_t;

    localparam int c_LOOPS = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        b_valid;
    logic        b_instr;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_wstrb;
    logic        b_clear;
    logic        clear_on_ready;

    wire  [31:0] s_ifetch0, s_read0, s_write0;
    wire  [31:0] s_ifetch1, s_read1, s_write1;

    int          n_err = 0;
    int          n_chk = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    logic [31:0] m_mem   [2][256];
    logic        m_known [2][256];
    int          m_if [2];
    int          m_rd [2];
    int          m_wr [2];
    logic [31:0] prog [7];

    always #5 clk = ~clk;

    mem_slave_wait_if bus0 ();
    mem_slave_wait_if bus1 ();

    assign bus0.mem_valid = b_valid & ~sel;
    assign bus0.mem_instr = b_instr;
    assign bus0.mem_addr  = b_addr;
    assign bus0.mem_wdata = b_wdata;
    assign bus0.mem_wstrb = b_wstrb;
    assign bus1.mem_valid = b_valid & sel;
    assign bus1.mem_instr = b_instr;
    assign bus1.mem_addr  = b_addr;
    assign bus1.mem_wdata = b_wdata;
    assign bus1.mem_wstrb = b_wstrb;

    wire        b_ready  = sel ? bus1.mem_ready : bus0.mem_ready;
    wire        b_error  = sel ? bus1.mem_error : bus0.mem_error;
    wire [31:0] b_rdata  = sel ? bus1.mem_rdata : bus0.mem_rdata;
    wire [31:0] b_ifetch = sel ? s_ifetch1 : s_ifetch0;
    wire [31:0] b_read   = sel ? s_read1   : s_read0;
    wire [31:0] b_write  = sel ? s_write1  : s_write0;

    mem_slave_wait #(
        .ADDR_BASE (32'h0), .DEPTH_WORDS (256), .WAIT_CYCLES (0), .CNT_W (32)
    ) u_dut0 (
        .clk (clk), .reset (reset), .bus (bus0.slave), .stat_clear (b_clear),
        .stat_ifetch (s_ifetch0), .stat_read (s_read0), .stat_write (s_write0)
    );

    mem_slave_wait #(
        .ADDR_BASE (32'h0), .DEPTH_WORDS (256), .WAIT_CYCLES (3), .CNT_W (32)
    ) u_dut3 (
        .clk (clk), .reset (reset), .bus (bus1.slave), .stat_clear (b_clear),
        .stat_ifetch (s_ifetch1), .stat_read (s_read1), .stat_write (s_write1)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", tag, act, exp, sel, $time);
        end
    endtask

    task automatic check_stats();
        int s;
        s = sel ? 1 : 0;
        check_eq("stat_ifetch", b_ifetch, 32'(m_if[s]));
        check_eq("stat_read",   b_read,   32'(m_rd[s]));
        check_eq("stat_write",  b_write,  32'(m_wr[s]));
    endtask

    task automatic clear_model_counts();
        for (int k = 0; k < 2; k++) begin
            m_if[k] = 0;
            m_rd[k] = 0;
            m_wr[k] = 0;
        end
    endtask

    // One bus transaction on the selected instance, started at a negedge
    task automatic xfer(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic hold);
        exp_t e;
        int   cyc;
        int   idx;
        int   s;
        logic hit;
        s   = sel ? 1 : 0;
        hit = (addr < 32'h400);
        idx = int'(addr[9:2]);
        e.err   = ~hit;
        e.known = ~hit | m_known[s][idx];
        e.rdata = hit ? m_mem[s][idx] : 32'h0;
        exp_q.push_back(e);
        b_valid = 1'b1;
        b_instr = instr;
        b_addr  = addr;
        b_wdata = wdata;
        b_wstrb = wstrb;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!b_ready && cyc < 40);
        check_eq("latency", 32'(cyc), (s == 1) ? 32'd4 : 32'd1);
        if (!b_ready) begin
            void'(exp_q.pop_back());
        end
        if (!hold) b_valid = 1'b0;
        if (clear_on_ready) b_clear = 1'b1;
        if (b_ready) begin
            if (hit) begin
                for (int l = 0; l < 4; l++) begin
                    if (wstrb[l]) m_mem[s][idx][8*l +: 8] = wdata[8*l +: 8];
                end
                if (wstrb == 4'hF) m_known[s][idx] = 1'b1;
            end
            if (clear_on_ready) begin
                clear_model_counts();
            end else if (hit) begin
                if (instr) m_if[s]++;
                if (wstrb == 4'h0 && !instr) m_rd[s]++;
                if (wstrb != 4'h0) m_wr[s]++;
            end
        end
        @(negedge clk);
        b_clear = 1'b0;
        check_eq("ready_pulse", 32'(b_ready), 32'd0);
    endtask

    // Compare every ready pulse against the oldest expected response
    always @(negedge clk) begin
        if (b_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_ready", 32'(b_ready), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("error", 32'(b_error), 32'(mon_e.err));
                if (mon_e.known) check_eq("rdata", b_rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete (errors=%0d)", n_err);
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        prog[0] = 32'h3FC0_0093; prog[1] = 32'h0000_0113; prog[2] = 32'h0020_A023;
        prog[3] = 32'h0000_A103; prog[4] = 32'h0011_0113; prog[5] = 32'h0020_A023;
        prog[6] = 32'hFF5F_F06F;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 256; j++) begin
                m_mem[k][j]   = 32'h0;
                m_known[k][j] = 1'b0;
            end
        end
        clear_model_counts();
        reset = 1'b1; sel = 1'b0; b_valid = 1'b0; b_instr = 1'b0; b_addr = 32'h0;
        b_wdata = 32'h0; b_wstrb = 4'h0; b_clear = 1'b0; clear_on_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        for (int k = 0; k < 2; k++) begin
            sel = (k == 1);
            #1;
            check_eq("rst_ready", 32'(b_ready), 32'd0);
            check_eq("rst_error", 32'(b_error), 32'd0);
            check_eq("rst_rdata", b_rdata, 32'h0);
            check_stats();
        end
        sel = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Zero wait states: store then load the top word
        xfer(1'b0, 32'h3FC, 32'h0000_00AA, 4'hF, 1'b0);
        xfer(1'b0, 32'h3FC, 32'h0,         4'h0, 1'b0);
        check_eq("sw_lw_value", b_rdata, 32'h0000_00AA);
        check_stats();

        // Partial write: response is the old word, then merged lanes
        xfer(1'b0, 32'h100, 32'h1234_5678, 4'hF, 1'b0);
        xfer(1'b0, 32'h100, 32'hAABB_CCDD, 4'b0101, 1'b0);
        check_eq("partial_old", b_rdata, 32'h1234_5678);
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        check_eq("partial_new", b_rdata, 32'h12BB_56DD);

        // Unmapped read and write: error, zero data, RAM and counters untouched
        xfer(1'b0, 32'h400, 32'h0,         4'h0, 1'b0);
        check_eq("miss_rdata", b_rdata, 32'h0);
        xfer(1'b0, 32'h400, 32'hDEAD_BEEF, 4'hF, 1'b0);
        check_stats();
        xfer(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0);
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);

        // Valid held across a completion is a fresh request, not a repeat
        xfer(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b1);
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        check_stats();

        // Three wait states: fetch latency and ifetch counter
        sel = 1'b1;
        @(negedge clk);
        xfer(1'b0, 32'h000, 32'h3FC0_0093, 4'hF, 1'b0);
        xfer(1'b1, 32'h000, 32'h0,         4'h0, 1'b0);
        check_eq("fetch_value", b_rdata, 32'h3FC0_0093);
        check_stats();

        // Valid dropped during the wait: no response, no write
        b_valid = 1'b1; b_instr = 1'b0; b_addr = 32'h000; b_wdata = 32'hFFFF_FFFF; b_wstrb = 4'hF;
        repeat (2) @(negedge clk);
        b_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("abort_ready", 32'(b_ready), 32'd0);
        xfer(1'b0, 32'h000, 32'h0, 4'h0, 1'b0);
        check_stats();

        // Reset while waiting: transaction dropped, counters cleared, RAM kept
        b_valid = 1'b1; b_addr = 32'h000; b_wdata = 32'h5555_5555; b_wstrb = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        b_valid = 1'b0;
        #1;
        check_eq("rst_wait_ready", 32'(b_ready), 32'd0);
        clear_model_counts();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("post_rst_ready", 32'(b_ready), 32'd0);
        check_stats();
        xfer(1'b0, 32'h000, 32'h0, 4'h0, 1'b0);
        check_eq("ram_kept", b_rdata, 32'h3FC0_0093);

        // Counter-loop program traffic on the zero-wait instance
        sel = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 7; k++) begin
            xfer(1'b0, 32'(4 * k), prog[k], 4'hF, 1'b0);
        end
        xfer(1'b0, 32'h3FC, 32'h0, 4'hF, 1'b0);
        for (int it = 0; it < c_LOOPS; it++) begin
            xfer(1'b1, 32'h00C, 32'h0, 4'h0, 1'b0);
            xfer(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0);
            v = m_mem[0][255];
            xfer(1'b1, 32'h010, 32'h0, 4'h0, 1'b0);
            xfer(1'b1, 32'h014, 32'h0, 4'h0, 1'b0);
            xfer(1'b0, 32'h3FC, v + 32'd1, 4'hF, 1'b0);
            xfer(1'b1, 32'h018, 32'h0, 4'h0, 1'b0);
        end
        xfer(1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0);
        check_eq("loop_word", b_rdata, 32'(c_LOOPS));
        repeat (3) @(negedge clk);
        check_eq("rdata_hold", b_rdata, 32'(c_LOOPS));
        check_stats();

        // Clear asserted during the response beats the increment
        clear_on_ready = 1'b1;
        xfer(1'b0, 32'h200, 32'hCAFE_F00D, 4'hF, 1'b0);
        clear_on_ready = 1'b0;
        check_stats();
        xfer(1'b0, 32'h200, 32'h0, 4'h0, 1'b0);
        check_eq("after_clear", b_rdata, 32'hCAFE_F00D);
        check_stats();

        repeat (3) @(negedge clk);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
